// File: rtl/fifo_fill_pkg.sv
// Shared types and constants for the FIFO write-side fill controller.
// LFSR constants exist only when FIFO_FILL_LFSR_EN is defined.
package fifo_fill_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

`ifdef FIFO_FILL_LFSR_EN
  // Right-shifting Galois taps for maximal-length sequences.
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED    = 32'd1;

  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return {24'd0, LFSR_TAPS_8};
      16:      return {16'd0, LFSR_TAPS_16};
      default: return LFSR_TAPS_32;
    endcase
  endfunction
`endif

endpackage

// File: rtl/fifo_fill_pattern.sv
// Write-data pattern source: incrementing counter, or Galois LFSR when FIFO_FILL_LFSR_EN is defined.
// Reloads its start value on load or reset; steps once per accepted write.
module fifo_fill_pattern
  import fifo_fill_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] pattern
);

  logic [DATA_W-1:0] pattern_next;

`ifdef FIFO_FILL_LFSR_EN
  localparam logic [DATA_W-1:0] TAPS  = DATA_W'(lfsr_taps(DATA_W));
  localparam logic [DATA_W-1:0] START = DATA_W'(LFSR_SEED);

  assign pattern_next = {1'b0, pattern[DATA_W-1:1]} ^ (pattern[0] ? TAPS : '0);
`else
  localparam logic [DATA_W-1:0] START = '0;

  assign pattern_next = pattern + DATA_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst || load) begin
      pattern <= START;
    end else if (advance) begin
      pattern <= pattern_next;
    end
  end

endmodule

// File: rtl/fifo_fill_ctrl.sv
// Fills the downstream FIFO in bursts once it reports empty; data pattern set by FIFO_FILL_LFSR_EN.
// First write lands max(1,SETTLE_CYC)+1 cycles after the start sample; fifo_full stalls and ends a burst.
module fifo_fill_ctrl
  import fifo_fill_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int DEPTH      = 256,
  parameter  int SETTLE_CYC = 2,
  parameter  int BURST_LEN  = 0,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic              fifo_almost_full,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              busy,
  output logic              burst_done,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [15:0]       burst_cnt
);

  // SETTLE always lasts at least one cycle, even with SETTLE_CYC = 0.
  localparam logic [3:0] SETTLE_LAST =
    (SETTLE_CYC <= 1) ? 4'd0 : 4'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] DEPTH_LIM = CNT_W'(DEPTH);

  state_t           state;
  logic [3:0]       settle_cnt;
  logic             start;
  logic             last_write;
  logic [CNT_W-1:0] wr_cnt_inc;

  assign start      = (state == IDLE) & enable & fifo_empty;
  assign fifo_wr_en = (state == WRITE) & ~fifo_full;
  assign wr_cnt_inc = (wr_cnt == DEPTH_LIM) ? wr_cnt : wr_cnt + CNT_W'(1);
  assign last_write = fifo_almost_full |
                      ((BURST_LEN != 0) && ((wr_cnt + CNT_W'(1)) == BURST_LIM));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      wr_cnt     <= '0;
      burst_cnt  <= '0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            wr_cnt     <= '0;
            busy       <= 1'b1;
          end
        end
        SETTLE: begin
          if (!fifo_empty) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (settle_cnt >= SETTLE_LAST) begin
            state <= WRITE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        WRITE: begin
          if (fifo_wr_en) begin
            wr_cnt <= wr_cnt_inc;
          end
          // fifo_full is an overflow guard: finish without writing.
          if (fifo_full || last_write) begin
            state      <= DONE;
            busy       <= 1'b0;
            burst_done <= 1'b1;
            burst_cnt  <= burst_cnt + 16'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  fifo_fill_pattern #(
    .DATA_W (DATA_W)
  ) u_pattern (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .load    (start),
    .advance (fifo_wr_en),
    .pattern (fifo_wr_data)
  );

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Bench for fifo_fill_ctrl: a free-running instance and a BURST_LEN=10 instance, each with a FIFO occupancy model.
module tb_fifo_fill_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int SC    = 2;
  localparam int BL    = 10;
  localparam int CW    = $clog2(DEPTH + 1);

`ifdef FIFO_FILL_LFSR_EN
  localparam logic [7:0] PSTART = 8'h01;
  function automatic logic [7:0] pat_next(input logic [7:0] p);
    return {1'b0, p[7:1]} ^ (p[0] ? 8'hB8 : 8'h00);
  endfunction
`else
  localparam logic [7:0] PSTART = 8'h00;
  function automatic logic [7:0] pat_next(input logic [7:0] p);
    return p + 8'd1;
  endfunction
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic en0 = 1'b0, en1 = 1'b0;
  logic force_full0 = 1'b0, force_nempty0 = 1'b0;
  logic clr0 = 1'b0, clr1 = 1'b0;
  int   fcnt0 = 0, fcnt1 = 0;

  logic empty0, af0, full0, empty1, af1, full1;
  assign empty0 = (fcnt0 == 0) && !force_nempty0;
  assign af0    = (fcnt0 == DEPTH - 1);
  assign full0  = (fcnt0 == DEPTH) || force_full0;
  assign empty1 = (fcnt1 == 0);
  assign af1    = (fcnt1 == DEPTH - 1);
  assign full1  = (fcnt1 == DEPTH);

  logic          wr_en0, busy0, done0, wr_en1, busy1, done1;
  logic [DW-1:0] data0, data1;
  logic [CW-1:0] wrc0, wrc1;
  logic [15:0]   bc0, bc1;

  fifo_fill_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .SETTLE_CYC(SC), .BURST_LEN(0)) dut0 (
    .sys_clk(clk), .sys_rst(rst), .enable(en0), .fifo_empty(empty0),
    .fifo_almost_full(af0), .fifo_full(full0), .fifo_wr_en(wr_en0),
    .fifo_wr_data(data0), .busy(busy0), .burst_done(done0), .wr_cnt(wrc0),
    .burst_cnt(bc0));

  fifo_fill_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .SETTLE_CYC(SC), .BURST_LEN(BL)) dut1 (
    .sys_clk(clk), .sys_rst(rst), .enable(en1), .fifo_empty(empty1),
    .fifo_almost_full(af1), .fifo_full(full1), .fifo_wr_en(wr_en1),
    .fifo_wr_data(data1), .busy(busy1), .burst_done(done1), .wr_cnt(wrc1),
    .burst_cnt(bc1));

  // FIFO occupancy models; the reader drains everything at once via clr.
  always @(posedge clk) begin
    if (rst || clr0) fcnt0 <= 0;
    else if (wr_en0 && fcnt0 < DEPTH) fcnt0 <= fcnt0 + 1;
    if (rst || clr1) fcnt1 <= 0;
    else if (wr_en1 && fcnt1 < DEPTH) fcnt1 <= fcnt1 + 1;
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int wcnt0 = 0, wcnt1 = 0, dcnt0 = 0, dcnt1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write must match the next queued expected word.
  always @(negedge clk) begin
    if (wr_en0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_write0 actual_data=%0h expected=no_write", data0);
      end else begin
        chk("wr_data0", data0, q0.pop_front());
      end
      wcnt0++;
    end
    if (wr_en1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_write1 actual_data=%0h expected=no_write", data1);
      end else begin
        chk("wr_data1", data1, q1.pop_front());
      end
      wcnt1++;
    end
    if (done0) dcnt0++;
    if (done1) dcnt1++;
  end

  task automatic push_burst(input int sel, input int n);
    logic [7:0] p;
    p = PSTART;
    for (int i = 0; i < n; i++) begin
      if (sel != 0) q1.push_back(p); else q0.push_back(p);
      p = pat_next(p);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_busy(input int sel);
    int k = 0;
    while (((sel != 0) ? busy1 : busy0) == 1'b0 && k < 50) begin tick(); k++; end
    chk("busy_seen", (sel != 0) ? busy1 : busy0, 1);
  endtask

  task automatic wait_done(input int sel, input int target);
    int k = 0;
    while (((sel != 0) ? dcnt1 : dcnt0) < target && k < 2000) begin tick(); k++; end
    chk("burst_done_seen", ((sel != 0) ? dcnt1 : dcnt0) >= target, 1);
  endtask

  typedef struct {
    int sel;
    int hold;
    int writes;
    int exp_wrc;
    int exp_bc;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int k, bw, bd, bb;
    vecs[0] = '{sel: 1, hold: 0, writes: BL,    exp_wrc: BL,    exp_bc: 1};
    vecs[1] = '{sel: 1, hold: 4, writes: BL,    exp_wrc: BL,    exp_bc: 2};
    vecs[2] = '{sel: 0, hold: 4, writes: DEPTH, exp_wrc: DEPTH, exp_bc: 2};
    vecs[3] = '{sel: 1, hold: 4, writes: BL,    exp_wrc: BL,    exp_bc: 3};

    // Reset held with enable and empty asserted.
    en0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_wr_en", wr_en0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_wr_cnt", wrc0, 0);
      chk("rst_burst_cnt", bc0, 0);
      chk("rst_data", data0, PSTART);
    end

    // First write latency, then reset mid-WRITE after 7 writes.
    push_burst(0, 7);
    rst = 1'b0;
    k = 0;
    while (!wr_en0 && k < 20) begin tick(); k++; end
    chk("first_write_latency", k, SC + 1);
    en0 = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk("abort_wr_en", wr_en0, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_wr_cnt", wrc0, 0);
    chk("abort_burst_cnt", bc0, 0);
    chk("abort_data", data0, PSTART);
    chk("abort_writes", wcnt0, 7);

    // Full fill: almost_full stops it after DEPTH writes; data restarts.
    push_burst(0, DEPTH);
    bw = wcnt0;
    en0 = 1'b1;
    rst = 1'b0;
    wait_busy(0);
    en0 = 1'b0;
    wait_done(0, 1);
    repeat (3) tick();
    chk("fill_writes", wcnt0 - bw, DEPTH);
    chk("fill_wr_cnt", wrc0, DEPTH);
    chk("fill_burst_cnt", bc0, 1);
    chk("fill_done_pulses", dcnt0, 1);
    chk("fill_queue_left", q0.size(), 0);

    // Table: enable held while FIFO not empty must not start; drain then burst.
    for (int v = 0; v < 4; v++) begin
      push_burst(vecs[v].sel, vecs[v].writes);
      bw = (vecs[v].sel != 0) ? wcnt1 : wcnt0;
      bd = (vecs[v].sel != 0) ? dcnt1 : dcnt0;
      if (vecs[v].sel != 0) en1 = 1'b1; else en0 = 1'b1;
      for (int h = 0; h < vecs[v].hold; h++) begin
        tick();
        chk("hold_idle", (vecs[v].sel != 0) ? busy1 : busy0, 0);
      end
      if (vecs[v].sel != 0) clr1 = 1'b1; else clr0 = 1'b1;
      tick();
      clr0 = 1'b0; clr1 = 1'b0;
      wait_busy(vecs[v].sel);
      en0 = 1'b0; en1 = 1'b0;
      wait_done(vecs[v].sel, bd + 1);
      repeat (3) tick();
      chk("vec_writes", ((vecs[v].sel != 0) ? wcnt1 : wcnt0) - bw, vecs[v].writes);
      chk("vec_wr_cnt", (vecs[v].sel != 0) ? wrc1 : wrc0, vecs[v].exp_wrc);
      chk("vec_burst_cnt", (vecs[v].sel != 0) ? bc1 : bc0, vecs[v].exp_bc);
      chk("vec_done_pulses", ((vecs[v].sel != 0) ? dcnt1 : dcnt0) - bd, 1);
      chk("vec_queue_left", (vecs[v].sel != 0) ? q1.size() : q0.size(), 0);
    end

    // fifo_full forced for 3 cycles after 5 writes ends the burst without writing.
    push_burst(0, 5);
    bw = wcnt0; bd = dcnt0; bb = bc0;
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    en0 = 1'b1;
    wait_busy(0);
    en0 = 1'b0;
    k = 0;
    while (!wr_en0 && k < 20) begin tick(); k++; end
    repeat (5) @(posedge clk);
    #1 force_full0 = 1'b1;
    #1 chk("full_no_write", wr_en0, 0);
    tick();
    chk("full_done", done0, 1);
    chk("full_burst_cnt", bc0, bb + 1);
    tick();
    chk("full_idle_no_write", wr_en0, 0);
    @(posedge clk);
    #1 force_full0 = 1'b0;
    repeat (3) tick();
    chk("full_writes", wcnt0 - bw, 5);
    chk("full_wr_cnt", wrc0, 5);
    chk("full_done_pulses", dcnt0 - bd, 1);

    // fifo_empty drops in SETTLE: back to IDLE with no writes, no count.
    bw = wcnt0; bd = dcnt0; bb = bc0;
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    en0 = 1'b1;
    @(posedge clk);
    #1 en0 = 1'b0;
    force_nempty0 = 1'b1;
    #1 chk("settle_busy", busy0, 1);
    tick();
    chk("settle_abort_busy", busy0, 0);
    repeat (6) tick();
    force_nempty0 = 1'b0;
    repeat (2) tick();
    chk("settle_abort_writes", wcnt0 - bw, 0);
    chk("settle_abort_done", dcnt0 - bd, 0);
    chk("settle_abort_burst_cnt", bc0, bb);
    chk("settle_abort_wr_cnt", wrc0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_fill_ctrl.md
# fifo_fill_ctrl

Write-side controller that sits directly upstream of the FIFO IP in the FIFO demo design. It waits for the FIFO to report empty, lets the IP's flags settle, then writes a deterministic data pattern one word per cycle until the FIFO is full or a burst limit is reached. After each burst it returns to idle. The read-side stage drains the FIFO independently.

## Interface
Parameters:
- DATA_W, 8, data width; must be 8, 16 or 32.
- DEPTH, 256, FIFO depth in words.
- SETTLE_CYC, 2, idle cycles after empty is seen before the first write (covers FIFO flag latency); range 0..15.
- BURST_LEN, 0, maximum words per burst; 0 means write until almost-full.

Ports:
- sys_clk  in  1  single clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- enable  in  1  permits a new burst; sampled only in IDLE.
- fifo_empty  in  1  FIFO empty flag, write-side view.
- fifo_almost_full  in  1  high when exactly one free slot remains.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  write strobe to FIFO.
- fifo_wr_data  out  DATA_W  write data; valid whenever fifo_wr_en is high.
- busy  out  1  high in SETTLE and WRITE.
- burst_done  out  1  one-cycle pulse on burst completion.
- wr_cnt  out  $clog2(DEPTH+1)  words written in the current or most recent burst.
- burst_cnt  out  16  number of completed bursts; wraps from 0xFFFF to 0.

## Operation
- FSM states: IDLE, SETTLE, WRITE, DONE. Reset puts the FSM in IDLE.
- Reset values: fifo_wr_en, busy, burst_done and wr_cnt are 0; burst_cnt is 0; fifo_wr_data is the pattern start value.
- IDLE → SETTLE when enable and fifo_empty are both high. On this transition, the settle counter is cleared, wr_cnt is cleared, and the pattern is reloaded to its start value.
- SETTLE:
  - If fifo_empty drops, return to IDLE. No write occurs.
  - After SETTLE_CYC cycles in SETTLE, go to WRITE. With SETTLE_CYC=0, SETTLE lasts exactly one cycle.
- WRITE:
  - fifo_wr_en = (state==WRITE) & ~fifo_full. It is combinational from the state register and fifo_full.
  - Each cycle with fifo_wr_en high is one accepted write. On an accepted write, the pattern advances and wr_cnt increments.
  - WRITE → DONE on any of the following:
    - an accepted write in a cycle where fifo_almost_full is high (that write fills the last slot);
    - an accepted write that makes wr_cnt equal BURST_LEN (when BURST_LEN≠0);
    - fifo_full high, which is an overflow guard and produces no write.
  - Simultaneous almost_full and BURST_LEN hit produce a single transition and a single count.
- DONE: exactly one cycle. burst_done=1 and burst_cnt increments. Next state is IDLE.
- enable is ignored outside IDLE. Deasserting it mid-burst does not stop the burst.
- Sync reset in any state: next cycle is IDLE with all reset values restored. A partially written burst is abandoned and is not counted.
- Pattern (default): incrementing counter starting at 0, wrapping modulo 2^DATA_W.
- wr_cnt saturates at DEPTH. It holds its value through IDLE until the next burst starts.

## Timing
- Let cycle N be the cycle in which IDLE samples enable & fifo_empty.
- SETTLE occupies cycles N+1 … N+max(1,SETTLE_CYC).
- The first fifo_wr_en is in cycle N+max(1,SETTLE_CYC)+1.
- Writes are back-to-back at one per cycle. The only bubbles are cycles with fifo_full high.
- burst_done is high in the cycle after the last write. burst_cnt reflects the new value in the same cycle as burst_done.
- The earliest next burst start is two cycles after the last write (DONE, then IDLE sample).
- fifo_wr_data changes only on the cycle after an accepted write, or on the reload into SETTLE.

## Configuration
- FIFO_FILL_LFSR_EN:
  - Defined: the pattern is a Galois LFSR. Its taps come from the package per DATA_W. The seed is 1 and is reloaded at each burst start. The LFSR advances once per accepted write.
  - Undefined: the incrementing counter is used. The LFSR logic and tap constants are not compiled.

## Structure
- Package fifo_fill_pkg:
  - state enum (IDLE/SETTLE/WRITE/DONE);
  - LFSR tap constants for 8/16/32 bits;
  - LFSR seed constant.
- Sub-module fifo_fill_pattern:
  - inputs: load, advance;
  - output: DATA_W pattern;
  - contains the counter/LFSR selection under FIFO_FILL_LFSR_EN.
- fifo_fill_ctrl holds the FSM, the settle counter, wr_cnt and burst_cnt.

## Test plan
- Reset held 5 cycles with enable=1 and fifo_empty=1, then released → all outputs 0 during reset. First fifo_wr_en is exactly SETTLE_CYC+1 cycles after the first IDLE sample, with fifo_wr_data=0x00.
- DEPTH=256 FIFO model, almost_full at 255 words → 256 writes with data 0x00…0xFF. One burst_done pulse, wr_cnt=256, burst_cnt=1.
- BURST_LEN=10 → 10 writes with data 0…9, then DONE. IDLE stays put until fifo_empty is reasserted after the reader drains.
- fifo_full forced high for 3 cycles mid-WRITE (almost_full low) → no writes in those cycles and the FSM goes to DONE. A fifo_empty drop during SETTLE → return to IDLE with zero writes.
- sys_rst asserted mid-WRITE → next cycle all outputs are reset and burst_cnt is unchanged from its pre-burst value. The next burst restarts data at 0.
- With FIFO_FILL_LFSR_EN and DATA_W=8 → first writes are 0x01 followed by the package-tap LFSR sequence, and the seed is reloaded on the second burst.
